// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Function : 32-cycle iterative signed MULT/DIV writing HI/LO registers.
// Revision : 1.0
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        readhilo,
    input  logic        spra,
    output logic [31:0] hilo_out,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_div;
    logic        r_sa;
    logic        r_sb;
    logic        r_bzero;
    logic [31:0] r_m;
    logic [31:0] r_wh;
    logic [31:0] r_wl;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_sum;
    logic [32:0] w_shl;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_neg;

    // 0x80000000 maps to itself, read as the unsigned magnitude 2^31.
    assign w_abs_a = a[31] ? (32'd0 - a) : a;
    assign w_abs_b = b[31] ? (32'd0 - b) : b;

    // Multiply step: conditional add of the multiplicand, then shift right.
    assign w_sum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_m} : 33'd0);

    // Divide step: shift the partial remainder left, trial-subtract the divisor.
    assign w_shl  = {r_wh, r_wl[31]};
    assign w_ge   = (w_shl >= {1'b0, r_m});
    assign w_diff = w_shl[31:0] - r_m;

    assign w_neg    = r_sa ^ r_sb;
    assign w_prod   = {r_wh, r_wl};
    assign w_prod_s = w_neg ? (64'd0 - w_prod) : w_prod;
    assign w_quo    = r_bzero ? 32'hFFFF_FFFF : (w_neg ? (32'd0 - r_wl) : r_wl);
    assign w_rem    = r_sa ? (32'd0 - r_wh) : r_wh;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bzero <= 1'b0;
            r_m     <= 32'd0;
            r_wh    <= 32'd0;
            r_wl    <= 32'd0;
            r_cnt   <= 5'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div   <= is_div;
                        r_sa    <= a[31];
                        r_sb    <= b[31];
                        r_bzero <= (b == 32'd0);
                        r_m     <= is_div ? w_abs_b : w_abs_a;
                        r_wh    <= 32'd0;
                        r_wl    <= is_div ? w_abs_a : w_abs_b;
                        r_cnt   <= 5'd0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_div) begin
                        r_wh <= w_ge ? w_diff : w_shl[31:0];
                        r_wl <= {r_wl[30:0], w_ge};
                    end else begin
                        r_wh <= w_sum[32:1];
                        r_wl <= {w_sum[0], r_wl[31:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod_s[63:32];
                        r_lo <= w_prod_s[31:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    // A HI/LO read issued alongside a launching MULT/DIV must also hold.
    assign stall    = (busy & (readhilo | start)) | (start & readhilo);
    assign done     = r_done;
    assign hilo_out = spra ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Function : Randomised scoreboard bench for muldiv_unit.
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        readhilo;
    logic        spra;
    logic        mon_spra;
    logic        drv_spra;
    logic [31:0] hilo_out;
    logic        busy;
    logic        stall;
    logic        done;

    assign spra = mon_spra | drv_spra;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_div   (is_div),
        .a        (a),
        .b        (b),
        .readhilo (readhilo),
        .spra     (spra),
        .hilo_out (hilo_out),
        .busy     (busy),
        .stall    (stall),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] v;
        int          c;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] last_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic; '/' and '%' truncate toward zero.
    function automatic logic [63:0] model(input logic d, input logic [31:0] x, input logic [31:0] y);
        longint la, lb, q, r;
        la = longint'($signed(x));
        lb = longint'($signed(y));
        if (!d) return la * lb;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: on every done pulse read HI and LO and compare with the queue head.
    always @(negedge clk) begin : mon
        logic [31:0] h;
        logic [31:0] l;
        exp_t        e;
        if (done === 1'b1) begin
            mon_spra = 1'b1;
            #1 h = hilo_out;
            mon_spra = 1'b0;
            #1 l = hilo_out;
            if (sb.size() == 0) begin
                check("done_without_request", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("hilo_result", {h, l}, e.v);
                check("latency", 64'(cyc), 64'(e.c));
            end
        end
    end

    task automatic launch(input logic d, input logic [31:0] x, input logic [31:0] y, input bit push);
        exp_t e;
        is_div = d;
        a      = x;
        b      = y;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.v = model(d, x, y);
            e.c = cyc + 33;
            sb.push_back(e);
            last_lo = e.v[31:0];
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(output int nb, output int ns);
        nb = 0;
        ns = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            if (stall === 1'b1) ns++;
            @(negedge clk);
        end
        if (nb >= 100) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic read_hilo(output logic [63:0] v);
        drv_spra = 1'b1;
        #1 v[63:32] = hilo_out;
        drv_spra = 1'b0;
        #1 v[31:0] = hilo_out;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        int          nb, ns;
        logic [63:0] v;
        logic [31:0] old;
        logic        d;
        logic [31:0] x, y;

        reset    = 1'b1;
        start    = 1'b0;
        is_div   = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        readhilo = 1'b0;
        drv_spra = 1'b0;
        mon_spra = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        read_hilo(v);
        check("reset_hilo", v, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        launch(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        wait_idle(nb, ns);
        check("mult_busy_cycles", 64'(nb), 64'd33);

        // Launch in the done cycle: back-to-back acceptance.
        launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle(nb, ns);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle(nb, ns);
        launch(1'b1, 32'h1234_5678, 32'd0, 1'b1);
        wait_idle(nb, ns);
        check("div0_busy_cycles", 64'(nb), 64'd33);

        // Second start while busy must be ignored.
        launch(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        repeat (3) @(negedge clk);
        is_div = 1'b0;
        a      = 32'd1;
        b      = 32'd1;
        start  = 1'b1;
        #1 check("stall_start_busy", 64'(stall), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        wait_idle(nb, ns);

        // Start during the FIX cycle must be ignored.
        launch(1'b0, 32'd12345, 32'd678, 1'b1);
        repeat (32) @(negedge clk);
        a     = 32'd5;
        b     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        wait_idle(nb, ns);
        @(negedge clk);
        check("fix_start_ignored", 64'(busy), 64'd0);

        // MULT with a HI/LO read held in decode.
        old      = last_lo;
        is_div   = 1'b0;
        a        = 32'd3;
        b        = 32'd4;
        start    = 1'b1;
        readhilo = 1'b1;
        #1 check("stall_on_start_read", 64'(stall), 64'd1);
        launch(1'b0, 32'd3, 32'd4, 1'b1);
        nb = 0;
        ns = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            if (stall === 1'b1) ns++;
            check("hilo_while_busy", 64'(hilo_out), 64'(old));
            @(negedge clk);
        end
        check("stall_cycles", 64'(ns), 64'd33);
        @(negedge clk);
        check("hilo_after_mult", 64'(hilo_out), 64'd12);
        check("stall_after_mult", 64'(stall), 64'd0);
        readhilo = 1'b0;

        // Reset mid-operation aborts without writing HI/LO.
        launch(1'b1, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        read_hilo(v);
        check("abort_hilo", v, 64'd0);
        last_lo = 32'd0;

        // Reset wins over start in the same cycle.
        is_div = 1'b0;
        a      = 32'd9;
        b      = 32'd9;
        start  = 1'b1;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("reset_over_start", 64'(busy), 64'd0);

        launch(1'b1, 32'd100, 32'd7, 1'b1);
        wait_idle(nb, ns);

        for (int i = 0; i < 24; i++) begin
            d = 1'($urandom_range(0, 1));
            x = pick();
            y = pick();
            launch(d, x, y, 1'b1);
            wait_idle(nb, ns);
            check("rand_busy_cycles", 64'(nb), 64'd33);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        wait_idle(nb, ns);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
